// File: rtl/tmds_pkg.sv
// Shared encodings for the TMDS lane control path.
package tmds_pkg;

  localparam int unsigned CHAR_BITS = 10;

  localparam logic [1:0] BLANK_SEL_VIDEO = 2'b00;
  localparam logic [1:0] BLANK_SEL_CTRL  = 2'b01;
  localparam logic [1:0] BLANK_SEL_GUARD = 2'b10;

endpackage

// File: rtl/video_raster_cnt.sv
// Horizontal/vertical raster counters; registers region, hsync and vsync for the slot
// that starts after each advance.
module video_raster_cnt
  import tmds_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned GUARD_LEN = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       adv,
  output logic [1:0] blank_sel,
  output logic       hsync,
  output logic       vsync,
  output logic       next_video_c,
  output logic       origin_c
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_W   = $clog2(H_TOT);
  localparam int unsigned V_W   = $clog2(V_TOT);

  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOT - 1);
  localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] H_GRD    = H_W'(H_TOT - GUARD_LEN);
  localparam logic [H_W-1:0] HS_BEG   = H_W'(H_ACTIVE + H_FRONT);
  localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOT - 1);
  localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] V_ACT_M1 = V_W'(V_ACTIVE - 1);
  localparam logic [V_W-1:0] VS_BEG   = V_W'(V_ACTIVE + V_FRONT);
  localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [H_W-1:0] h_q, h_d, h_nxt;
  logic [V_W-1:0] v_q, v_d, v_nxt;
  logic [1:0]     blank_sel_q, blank_sel_d, region_nxt;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;

  // Guard band precedes any line whose successor is active, including the frame wrap.
  function automatic logic [1:0] region(input logic [H_W-1:0] h, input logic [V_W-1:0] v);
    if (h < H_ACT && v < V_ACT)
      return BLANK_SEL_VIDEO;
    else if (h >= H_GRD && (v < V_ACT_M1 || v == V_LAST))
      return BLANK_SEL_GUARD;
    else
      return BLANK_SEL_CTRL;
  endfunction

  always_comb begin
    h_d         = h_q;
    v_d         = v_q;
    blank_sel_d = blank_sel_q;
    hsync_d     = hsync_q;
    vsync_d     = vsync_q;
    h_nxt       = (h_q == H_LAST) ? '0 : h_q + 1'b1;
    v_nxt       = v_q;
    if (h_q == H_LAST) v_nxt = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    region_nxt  = region(h_nxt, v_nxt);
    if (adv) begin
      h_d         = h_nxt;
      v_d         = v_nxt;
      blank_sel_d = region_nxt;
      hsync_d     = (h_nxt >= HS_BEG) && (h_nxt < HS_END);
      vsync_d     = (v_nxt >= VS_BEG) && (v_nxt < VS_END);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      h_q         <= '0;
      v_q         <= '0;
      blank_sel_q <= BLANK_SEL_CTRL;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      blank_sel_q <= blank_sel_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
    end
  end

  assign blank_sel    = blank_sel_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign next_video_c = (region_nxt == BLANK_SEL_VIDEO);
  assign origin_c     = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/tmds_timing_ctrl.sv
// Per-lane TMDS control: splits the bit clock into 10-bit character slots and decodes
// the encoder load strobes, shift-register ping-pong and raster outputs.
module tmds_timing_ctrl
  import tmds_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned GUARD_LEN = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       en,
  output logic       pixel_req,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic [1:0] blank_sel,
  output logic       D1_load,
  output logic       D2_load,
  output logic       S1_load,
  output logic       S2_load,
  output logic       SR0_load,
  output logic       SR1_load,
  output logic       out_sel
);

  localparam int unsigned       BIT_W    = $clog2(CHAR_BITS);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(CHAR_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_REQ  = BIT_W'(CHAR_BITS - 2);

  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             ping_q, ping_d;
  logic             out_sel_q, out_sel_d;
  logic             wrap_c;
  logic             next_video_c;
  logic             origin_c;

  assign wrap_c = en && (bit_cnt_q == BIT_LAST);

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    ping_d    = ping_q;
    out_sel_d = out_sel_q;
    if (en) bit_cnt_d = wrap_c ? '0 : bit_cnt_q + 1'b1;
    // Serialise from the register just loaded; the other one becomes the next load target.
    if (wrap_c) begin
      out_sel_d = ping_q;
      ping_d    = ~ping_q;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt_q <= '0;
      ping_q    <= 1'b0;
      out_sel_q <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      ping_q    <= ping_d;
      out_sel_q <= out_sel_d;
    end
  end

  video_raster_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK),
    .GUARD_LEN(GUARD_LEN)
  ) u_raster (
    .clk         (clk),
    .n_rst       (n_rst),
    .adv         (wrap_c),
    .blank_sel   (blank_sel),
    .hsync       (hsync),
    .vsync       (vsync),
    .next_video_c(next_video_c),
    .origin_c    (origin_c)
  );

  // Moore strobe decode of the slot position, gated by en.
  always_comb begin
    D1_load     = en && (bit_cnt_q == BIT_W'(0));
    D2_load     = en && (bit_cnt_q == BIT_W'(1));
    S1_load     = en && (bit_cnt_q == BIT_W'(2));
    S2_load     = en && (bit_cnt_q == BIT_W'(3));
    SR0_load    = wrap_c && !ping_q;
    SR1_load    = wrap_c && ping_q;
    pixel_req   = en && (bit_cnt_q == BIT_REQ) && next_video_c;
    frame_start = en && (bit_cnt_q == BIT_W'(0)) && origin_c;
  end

  assign out_sel = out_sel_q;

endmodule
